// File: rtl/axis_frame_fifo_8.sv
// Store-and-forward frame FIFO for an 8-bit AXI stream: frames are released only
// after their tlast beat is committed; bad (tuser) and oversize frames are dropped.
module axis_frame_fifo_8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);

    ptr_t wr_ptr;
    ptr_t wr_ptr_cur;
    ptr_t rd_ptr;
    logic drop_frame;

    logic [DATA_WIDTH:0] mem [DEPTH];

    ptr_t cur_used;
    ptr_t frame_used;
    logic empty;
    logic full_cur;
    logic full_wr;
    logic in_fire;
    logic wr_en;
    logic rd_en;

    assign cur_used   = wr_ptr_cur - rd_ptr;
    assign frame_used = wr_ptr_cur - wr_ptr;
    assign empty      = (rd_ptr == wr_ptr);
    assign full_cur   = (cur_used == DEPTH_PTR);
    assign full_wr    = (frame_used == DEPTH_PTR);

    // A frame that alone fills the RAM keeps ready high so it can be drained and dropped.
    assign input_axis_tready = !full_cur || full_wr || drop_frame;
    assign in_fire           = input_axis_tvalid && input_axis_tready;
    assign wr_en             = in_fire && !drop_frame && !full_wr;
    assign rd_en             = !empty && (!output_axis_tvalid || output_axis_tready);

    // NOTE: the RAM has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tdata};
        end
    end

    // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            wr_ptr_cur <= '0;
            drop_frame <= 1'b0;
            overflow   <= 1'b0;
            bad_frame  <= 1'b0;
            good_frame <= 1'b0;
        end else begin
            overflow   <= 1'b0;
            bad_frame  <= 1'b0;
            good_frame <= 1'b0;
            if (in_fire) begin
                if (drop_frame) begin
                    if (input_axis_tlast) begin
                        drop_frame <= 1'b0;
                        overflow   <= 1'b1;
                    end
                end else if (full_wr) begin
                    wr_ptr_cur <= wr_ptr;
                    if (input_axis_tlast) begin
                        overflow <= 1'b1;
                    end else begin
                        drop_frame <= 1'b1;
                    end
                end else if (input_axis_tlast && input_axis_tuser) begin
                    wr_ptr_cur <= wr_ptr;
                    bad_frame  <= 1'b1;
                end else begin
                    wr_ptr_cur <= wr_ptr_cur + 1'b1;
                    if (input_axis_tlast) begin
                        wr_ptr     <= wr_ptr_cur + 1'b1;
                        good_frame <= 1'b1;
                    end
                end
            end
        end
    end

    // Single registered output stage; it only sees committed data through wr_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr             <= '0;
            output_axis_tvalid <= 1'b0;
            output_axis_tdata  <= '0;
            output_axis_tlast  <= 1'b0;
        end else if (rd_en) begin
            {output_axis_tlast, output_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            rd_ptr             <= rd_ptr + 1'b1;
            output_axis_tvalid <= 1'b1;
        end else if (output_axis_tready) begin
            output_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_frame_fifo_8.sv
// Directed scoreboard bench for axis_frame_fifo_8: expected beats are queued when
// a frame that must survive is driven, and popped as the DUT hands beats downstream.
module tb_axis_frame_fifo_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] input_axis_tdata;
    logic       input_axis_tvalid;
    logic       input_axis_tready;
    logic       input_axis_tlast;
    logic       input_axis_tuser;
    logic [7:0] output_axis_tdata;
    logic       output_axis_tvalid;
    logic       output_axis_tready;
    logic       output_axis_tlast;
    logic       overflow;
    logic       bad_frame;
    logic       good_frame;

    axis_frame_fifo_8 dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .input_axis_tlast   (input_axis_tlast),
        .input_axis_tuser   (input_axis_tuser),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .output_axis_tlast  (output_axis_tlast),
        .overflow           (overflow),
        .bad_frame          (bad_frame),
        .good_frame         (good_frame)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int good_cnt    = 0;
    int bad_cnt     = 0;
    int ovf_cnt     = 0;
    int out_beats   = 0;
    int stall_cycles = 0;

    logic [8:0] exp_q[$];
    logic [7:0] frm[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Output monitor: a beat transfers on the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (good_frame) good_cnt++;
        if (bad_frame)  bad_cnt++;
        if (overflow)   ovf_cnt++;
        if (output_axis_tvalid && output_axis_tready) begin
            out_beats++;
            if (exp_q.size() == 0) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL spurious_output: observed byte %h tlast %b, expected no output",
                           output_axis_tdata, output_axis_tlast);
                end
            end else begin
                check("out_beat", {23'b0, output_axis_tlast, output_axis_tdata}, {23'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Drive one beat from posedge+1 and hold it until it is accepted.
    task automatic send(input logic [7:0] d, input logic l, input logic u);
        int n;
        input_axis_tdata  = d;
        input_axis_tlast  = l;
        input_axis_tuser  = u;
        input_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!input_axis_tready && n < 200) begin
            n++;
            stall_cycles++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout_ready", input_axis_tready, 1);
        @(posedge clk);
        #1;
        input_axis_tvalid = 1'b0;
        input_axis_tlast  = 1'b0;
        input_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic user, input bit expect_out);
        for (int i = 0; i < frm.size(); i++) begin
            send(frm[i], (i == frm.size() - 1), user && (i == frm.size() - 1));
        end
        if (expect_out) begin
            for (int i = 0; i < frm.size(); i++) begin
                exp_q.push_back({(i == frm.size() - 1), frm[i]});
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    int g0, b0, o0, s0;
    logic [7:0] hold_d;
    logic       hold_l;

    initial begin
        rst                = 1'b1;
        input_axis_tdata   = '0;
        input_axis_tvalid  = 1'b0;
        input_axis_tlast   = 1'b0;
        input_axis_tuser   = 1'b0;
        output_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_tvalid", output_axis_tvalid, 0);
        check("rst_out_tdata",  output_axis_tdata, 0);
        check("rst_out_tlast",  output_axis_tlast, 0);
        check("rst_pulses",     {overflow, bad_frame, good_frame}, 0);
        check("rst_in_tready",  input_axis_tready, 1);

        // Good frame: nothing out before tlast, first byte one edge after tlast
        g0 = good_cnt;
        frm = {8'hcd, 8'hab, 8'hcd, 8'hab, 8'hcd};
        send_frame(1'b0, 1'b1);
        check("good_pulse_at_tlast", good_frame, 1);
        check("no_valid_at_tlast_edge", output_axis_tvalid, 0);
        @(posedge clk);
        #1;
        check("first_valid_latency", output_axis_tvalid, 1);
        check("first_byte", output_axis_tdata, 8'hcd);
        check("first_byte_tlast", output_axis_tlast, 0);
        drain();
        check("good_frame_count", good_cnt - g0, 1);

        // Bad frame dropped, following good frame passes
        b0 = bad_cnt;
        frm = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1'b1, 1'b0);
        check("bad_pulse_at_tlast", bad_frame, 1);
        frm = {8'h55, 8'h66};
        send_frame(1'b0, 1'b1);
        drain();
        check("bad_frame_count", bad_cnt - b0, 1);

        // Oversize frame dropped without back-pressure
        o0 = ovf_cnt;
        s0 = stall_cycles;
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'(i));
        send_frame(1'b0, 1'b0);
        check("overflow_pulse_at_tlast", overflow, 1);
        @(posedge clk);
        #1;
        check("overflow_one_cycle", overflow, 0);
        check("oversize_no_stall", stall_cycles - s0, 0);
        frm = {8'ha0, 8'ha1};
        send_frame(1'b0, 1'b1);
        drain();
        check("overflow_count", ovf_cnt - o0, 1);

        // Back-pressure: second frame stalls once 16 entries are held
        output_axis_tready = 1'b0;
        frm.delete();
        for (int i = 0; i < 10; i++) frm.push_back(8'h10 + 8'(i));
        send_frame(1'b0, 1'b1);
        frm.delete();
        for (int i = 0; i < 10; i++) frm.push_back(8'h20 + 8'(i));
        for (int i = 0; i < 7; i++) send(frm[i], 1'b0, 1'b0);
        input_axis_tdata  = frm[7];
        input_axis_tvalid = 1'b1;
        @(negedge clk);
        check("bp_ready_low", input_axis_tready, 0);
        repeat (2) @(negedge clk);
        check("bp_ready_still_low", input_axis_tready, 0);
        @(posedge clk);
        #1;
        output_axis_tready = 1'b1;
        for (int i = 7; i < 10; i++) send(frm[i], (i == 9), 1'b0);
        for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), frm[i]});
        drain();

        // Output stall mid-frame: ready pattern 1,0,0,1
        frm = {8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        send_frame(1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        output_axis_tready = 1'b0;
        hold_d = output_axis_tdata;
        hold_l = output_axis_tlast;
        check("stall_byte", hold_d, 8'h41);
        @(posedge clk);
        #1;
        check("stall_hold_data_1", output_axis_tdata, hold_d);
        check("stall_hold_tlast_1", output_axis_tlast, hold_l);
        check("stall_hold_valid_1", output_axis_tvalid, 1);
        @(posedge clk);
        #1;
        check("stall_hold_data_2", output_axis_tdata, hold_d);
        check("stall_hold_valid_2", output_axis_tvalid, 1);
        output_axis_tready = 1'b1;
        drain();

        // Reset mid-frame with a stored frame parked in the output stage
        output_axis_tready = 1'b0;
        frm = {8'he1, 8'he2};
        send_frame(1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", output_axis_tvalid, 1);
        frm = {8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
        for (int i = 0; i < 3; i++) send(frm[i], 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_tvalid", output_axis_tvalid, 0);
        check("mid_rst_out_tdata",  output_axis_tdata, 0);
        check("mid_rst_out_tlast",  output_axis_tlast, 0);
        check("mid_rst_pulses",     {overflow, bad_frame, good_frame}, 0);
        check("mid_rst_in_tready",  input_axis_tready, 1);
        output_axis_tready = 1'b1;
        frm = {8'h77, 8'h88};
        send_frame(1'b0, 1'b1);
        drain();

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("total_output_beats", out_beats, 37);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_frame_fifo_8.md
Name: axis_frame_fifo_8

Overview:
- Store-and-forward frame FIFO for 8-bit AXI stream. It sits directly downstream of the 64->8 axis_adapter output.
- A frame is only released on the output after its tlast beat has been written.
- Frames flagged bad (tuser=1 on the tlast beat) are discarded. Frames longer than the FIFO depth are discarded.
- Guarantees the downstream consumer never sees a partial or errored frame.

Parameters:
- DATA_WIDTH, 8, tdata width; tkeep is not carried.
- ADDR_WIDTH, 4, log2 of FIFO depth; DEPTH = 2^ADDR_WIDTH = 16 entries of {tlast, tdata}.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- input_axis_tdata  input  DATA_WIDTH  input data.
- input_axis_tvalid  input  1  input valid.
- input_axis_tready  output  1  input ready.
- input_axis_tlast  input  1  last beat of frame.
- input_axis_tuser  input  1  bad-frame flag; sampled on the tlast beat only.
- output_axis_tdata  output  DATA_WIDTH  output data.
- output_axis_tvalid  output  1  output valid.
- output_axis_tready  input  1  output ready.
- output_axis_tlast  output  1  last beat of frame.
- overflow  output  1  1-cycle pulse: oversize frame dropped.
- bad_frame  output  1  1-cycle pulse: tuser-flagged frame dropped.
- good_frame  output  1  1-cycle pulse: frame committed.

Behaviour:
- Pointers:
  - wr_ptr (committed), wr_ptr_cur (speculative) and rd_ptr, each ADDR_WIDTH+1 bits.
  - Pointers wrap modulo 2^(ADDR_WIDTH+1); RAM is indexed by the low ADDR_WIDTH bits.
- Derived conditions:
  - empty = (rd_ptr == wr_ptr).
  - full_cur = (wr_ptr_cur - rd_ptr == DEPTH).
  - full_wr = (wr_ptr_cur - wr_ptr == DEPTH), meaning the current frame alone fills the RAM.
- Ready: input_axis_tready = !full_cur || full_wr || drop_frame.
  - Back-pressure applies only when committed data is occupying space.
- Accepted beat (tvalid && tready), not dropping:
  - If !full_wr: write {tlast, tdata} at wr_ptr_cur and increment wr_ptr_cur.
  - If full_wr: do not write; set wr_ptr_cur <= wr_ptr and set drop_frame.
    - If this beat is also tlast, pulse overflow and clear drop_frame immediately.
- Accepted beat while drop_frame=1: discard it. On tlast, clear drop_frame and pulse overflow.
- Committed tlast beat (written, drop_frame=0):
  - tuser=0: wr_ptr <= wr_ptr_cur+1 (tlast entry included); pulse good_frame.
  - tuser=1: wr_ptr_cur <= wr_ptr (rollback); pulse bad_frame; wr_ptr unchanged.
- Read side:
  - One registered output stage. It loads from RAM[rd_ptr] and increments rd_ptr when !empty && (!output_axis_tvalid || output_axis_tready).
  - output_axis_tvalid clears when output_axis_tready && the stage is not reloaded.
- Latency: if tlast is accepted at edge k, output_axis_tvalid is 1 from edge k+1 with the first frame byte.
- Sustained throughput: 1 beat/cycle on each side.
- Output data/tlast hold stable while tvalid=1 && tready=0.
- Simultaneous read and commit in the same cycle are both legal. The read uses the pre-edge wr_ptr.
- Reset (mid-frame included):
  - All pointers return to 0; drop_frame=0.
  - output_axis_tvalid, output_axis_tdata, output_axis_tlast, overflow, bad_frame, good_frame all go to 0.
  - Any partial or stored frame is lost.
  - input_axis_tready = 1 after reset.
- Pulse outputs are registered, high for exactly one cycle, and are 0 in all other cycles.

Test Plan:
- Good frame: 5 beats cd,ab,cd,ab,cd with tlast on beat 5, tuser=0, output_axis_tready=1.
  - good_frame pulses once.
  - Output cd,ab,cd,ab,cd with output_axis_tlast=1 only on the 5th byte.
  - First output valid one edge after the tlast edge; no output before tlast.
- Bad frame: 4 beats 11,22,33,44 with tuser=1 on tlast, followed by good frame 55,66 (tlast).
  - bad_frame pulses once.
  - Output is only 55,66 with tlast on 66.
- Oversize frame: 20 beats 00..13 with tlast on 13, empty FIFO.
  - input_axis_tready stays 1 throughout.
  - overflow pulses once at the tlast beat.
  - No output.
  - A following 2-byte frame a0,a1 passes intact.
- Back-pressure: two 10-byte frames back-to-back with output_axis_tready=0.
  - After frame 1 commits, input_axis_tready drops when 16 entries are occupied.
  - Raise output_axis_tready: all 20 bytes emerge in order, tlast on bytes 10 and 20, no loss or duplication.
- Output stall: mid-frame, toggle output_axis_tready 1,0,0,1.
  - output_axis_tdata/tlast hold during the stall.
  - Byte order is preserved.
- Reset mid-frame: assert rst for 1 cycle after beat 3 of a 5-beat frame, then send frame 77,88 (tlast).
  - All outputs are 0 the cycle after reset.
  - Only 77,88 is output.
